// File: rtl/jt_romrq.sv
// Per-client ROM read slot: maps a client address onto a 32-bit SDRAM line and
// keeps a two-line shift cache so repeated reads within a line skip the SDRAM.
module jt_romrq #(
  parameter int unsigned SDRAMW = 22,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8   // 8, 16 or 32 only
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [SDRAMW-1:0] offset,
  input  logic [AW-1:0]     addr,
  input  logic              addr_ok,
  output logic [SDRAMW-1:0] sdram_addr,
  input  logic [31:0]       din,
  input  logic              din_ok,
  input  logic              we,
  output logic              req,
  output logic              data_ok,
  output logic [DW-1:0]     dout
);

  localparam int unsigned Shift = (DW == 8) ? 2 : (DW == 16) ? 1 : 0;

  logic [AW-1:0] line;
  logic [1:0]    valid_q;
  logic [AW-1:0] tag_q  [2];
  logic [31:0]   data_q [2];
  logic [AW-1:0] pend_q;
  logic          hit0, hit1, hit;
  logic [31:0]   sel_data;

  assign line       = addr >> Shift;
  assign sdram_addr = offset + (SDRAMW'(line) << 1);

  assign hit0    = valid_q[0] && (tag_q[0] == line);
  assign hit1    = valid_q[1] && (tag_q[1] == line);
  assign hit     = addr_ok && (hit0 || hit1);
  assign req     = addr_ok && !hit;
  assign data_ok = hit;

  // E0 wins when both entries match; with no hit E0 data is presented anyway.
  assign sel_data = (hit0 || !hit1) ? data_q[0] : data_q[1];

  if (DW == 8) begin : g_byte
    assign dout = sel_data[{addr[1:0], 3'b000} +: DW];
  end else if (DW == 16) begin : g_half
    assign dout = sel_data[{addr[0], 4'b0000} +: DW];
  end else begin : g_word
    assign dout = sel_data[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      pend_q    <= '0;
    end else begin
      // pend freezes while the arbiter serves us, so the fill is tagged with
      // the line that was actually requested even if addr has moved on.
      if (!we) pend_q <= line;
      if (clr) begin
        valid_q <= '0;
      end else if (we && din_ok) begin
        valid_q   <= {valid_q[0], 1'b1};
        tag_q[1]  <= tag_q[0];
        data_q[1] <= data_q[0];
        tag_q[0]  <= pend_q;
        data_q[0] <= din;
      end
    end
  end

endmodule

// File: tb/tb_jt_romrq.sv
// Bench for jt_romrq: three instances (DW=8/16/32) share one stimulus stream and
// are checked against an MRU-list model through an expectation queue.
module tb_jt_romrq;

  localparam int SW = 22;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, clr, addr_ok, din_ok, we;
  logic [SW-1:0] offset;
  logic [AW-1:0] addr;
  logic [31:0]   din;

  logic [SW-1:0] sa8, sa16, sa32;
  logic          req8, req16, req32, ok8, ok16, ok32;
  logic [7:0]    d8;
  logic [15:0]   d16;
  logic [31:0]   d32;

  always #5 clk = ~clk;

  jt_romrq #(.SDRAMW(SW), .AW(AW), .DW(8)) u_dw8 (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr), .addr_ok(addr_ok),
    .sdram_addr(sa8), .din(din), .din_ok(din_ok), .we(we), .req(req8), .data_ok(ok8),
    .dout(d8)
  );
  jt_romrq #(.SDRAMW(SW), .AW(AW), .DW(16)) u_dw16 (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr), .addr_ok(addr_ok),
    .sdram_addr(sa16), .din(din), .din_ok(din_ok), .we(we), .req(req16), .data_ok(ok16),
    .dout(d16)
  );
  jt_romrq #(.SDRAMW(SW), .AW(AW), .DW(32)) u_dw32 (
    .clk(clk), .rst(rst), .clr(clr), .offset(offset), .addr(addr), .addr_ok(addr_ok),
    .sdram_addr(sa32), .din(din), .din_ok(din_ok), .we(we), .req(req32), .data_ok(ok32),
    .dout(d32)
  );

  // Reference model: per width, a most-recent-first list of at most two lines.
  typedef struct packed {
    logic [AW-1:0] line;
    logic [31:0]   data;
  } ent_t;

  typedef struct packed {
    logic [2:0]          req;
    logic [2:0]          ok;
    logic [2:0][SW-1:0]  sa;
    logic [2:0][31:0]    dt;
  } exp_t;

  ent_t          lst  [3][2];
  int            cnt  [3];
  logic [AW-1:0] pend [3];
  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [SW-1:0] cur_off;

  function automatic logic [AW-1:0] line_of(input int k, input logic [AW-1:0] a);
    return a >> (2 - k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      cnt[k]  = 0;
      pend[k] = '0;
    end
  endtask

  // State change at a rising edge, using the inputs held before that edge.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        cnt[k] = 0;
      end else if (we && din_ok) begin
        lst[k][1] = lst[k][0];
        lst[k][0] = '{line: pend[k], data: din};
        if (cnt[k] < 2) cnt[k]++;
      end
      if (!we) pend[k] = line_of(k, addr);
    end
  endtask

  task automatic push_exp();
    exp_t          e;
    logic [AW-1:0] l;
    logic [31:0]   d;
    logic          found;
    for (int k = 0; k < 3; k++) begin
      l = line_of(k, addr);
      found = 1'b0;
      d = '0;
      for (int i = 0; i < cnt[k]; i++) begin
        if (!found && lst[k][i].line == l) begin
          found = 1'b1;
          d = lst[k][i].data;
        end
      end
      e.req[k] = addr_ok && !found;
      e.ok[k]  = addr_ok && found;
      e.sa[k]  = offset + (SW'(l) << 1);
      if (k == 0)      e.dt[k] = (d >> (8 * addr[1:0])) & 32'hFF;
      else if (k == 1) e.dt[k] = (d >> (16 * addr[0])) & 32'hFFFF;
      else             e.dt[k] = d;
    end
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s dw%0d @%0t: got %h, expected %h", nm, 8 << k, $time, act, want);
    end
  endtask

  initial begin
    exp_t        e;
    logic [2:0]  r_a, o_a;
    logic [31:0] s_a [3];
    logic [31:0] d_a [3];
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        r_a = {req32, req16, req8};
        o_a = {ok32, ok16, ok8};
        s_a[0] = 32'(sa8);  s_a[1] = 32'(sa16); s_a[2] = 32'(sa32);
        d_a[0] = 32'(d8);   d_a[1] = 32'(d16);  d_a[2] = d32;
        for (int k = 0; k < 3; k++) begin
          chk("req", k, 32'(r_a[k]), 32'(e.req[k]));
          chk("data_ok", k, 32'(o_a[k]), 32'(e.ok[k]));
          chk("sdram_addr", k, s_a[k], 32'(e.sa[k]));
          if (e.ok[k]) chk("dout", k, d_a[k], e.dt[k]);
        end
      end
    end
  end

  task automatic apply(input logic a_ok, input logic [AW-1:0] a, input logic w,
                       input logic dok, input logic [31:0] d, input logic c);
    @(posedge clk);
    model_edge();
    #1;
    addr_ok = a_ok;
    addr    = a;
    we      = w;
    din_ok  = dok;
    din     = d;
    clr     = c;
    offset  = cur_off;
    push_exp();
  endtask

  task automatic fill(input logic [AW-1:0] a, input logic [31:0] d);
    apply(1'b1, a, 1'b0, 1'b0, '0, 1'b0);
    apply(1'b1, a, 1'b1, 1'b0, '0, 1'b0);
    apply(1'b1, a, 1'b1, 1'b1, d, 1'b0);
    apply(1'b1, a, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; addr_ok = 1'b0; din_ok = 1'b0; we = 1'b0;
    addr = '0; din = '0; offset = '0; cur_off = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Miss, then fill, then hits within the same line.
    cur_off = 22'h100;
    apply(1'b1, 8'h05, 1'b1, 1'b0, '0, 1'b0);
    apply(1'b1, 8'h05, 1'b1, 1'b1, 32'hDDCCBBAA, 1'b0);
    apply(1'b1, 8'h05, 1'b0, 1'b0, '0, 1'b0);
    apply(1'b1, 8'h07, 1'b0, 1'b0, '0, 1'b0);

    // Shift replacement: line 1, 2, revisit 1, then 3 evicts 1.
    fill(8'h04, 32'h11111111);
    fill(8'h08, 32'h22222222);
    apply(1'b1, 8'h05, 1'b0, 1'b0, '0, 1'b0);
    fill(8'h0C, 32'h33333333);
    apply(1'b1, 8'h04, 1'b0, 1'b0, '0, 1'b0);

    // Half-word select and word-mode addressing.
    fill(8'h03, 32'h56781234);
    cur_off = '0;
    apply(1'b1, 8'h04, 1'b0, 1'b0, '0, 1'b0);

    // Address moves while the arbiter is serving the slot.
    apply(1'b1, 8'h20, 1'b0, 1'b0, '0, 1'b0);
    apply(1'b1, 8'h20, 1'b1, 1'b0, '0, 1'b0);
    apply(1'b1, 8'h30, 1'b1, 1'b0, '0, 1'b0);
    apply(1'b1, 8'h30, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0);
    apply(1'b1, 8'h30, 1'b0, 1'b0, '0, 1'b0);
    apply(1'b1, 8'h20, 1'b0, 1'b0, '0, 1'b0);

    // Invalidate, invalidate racing a fill, and foreign din_ok.
    apply(1'b1, 8'h20, 1'b0, 1'b0, '0, 1'b1);
    apply(1'b1, 8'h20, 1'b0, 1'b0, '0, 1'b0);
    fill(8'h40, 32'h0BADBEEF);
    apply(1'b1, 8'h44, 1'b1, 1'b1, 32'h12345678, 1'b1);
    apply(1'b1, 8'h40, 1'b0, 1'b1, 32'h87654321, 1'b0);
    apply(1'b1, 8'h40, 1'b0, 1'b0, '0, 1'b0);
    apply(1'b0, 8'h40, 1'b0, 1'b0, '0, 1'b0);

    // Randomized traffic over a small address window to get frequent hits.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) cur_off = SW'($urandom);
      apply($urandom_range(0, 7) != 0, AW'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom,
            $urandom_range(0, 39) == 0);
    end

    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jt_romrq.md
Name: jt_romrq

Overview:
- Per-client read-request slot for a shared SDRAM ROM arbiter.
- Converts a client byte, half-word or word address into a 32-bit-line SDRAM request.
- Keeps a 2-entry line cache so repeated reads in the same line need no SDRAM access.
- Returns the selected 8/16/32-bit datum with a combinational ok flag. One instance per arbiter slot.

Parameters:
- SDRAMW, 22, SDRAM word-address width (SDRAM word = 16 bits).
- AW, 8, client address width.
- DW, 8, client data width; legal values are 8, 16 and 32 only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous cache invalidate.
- offset  in  SDRAMW  base SDRAM word address of this ROM region.
- addr  in  AW  client address, in units of DW.
- addr_ok  in  1  client chip-select; addr is valid and a read is wanted.
- sdram_addr  out  SDRAMW  SDRAM word address of the line for the current addr; combinational.
- din  in  32  SDRAM read data; lower SDRAM word in [15:0], next word in [31:16].
- din_ok  in  1  din valid this cycle.
- we  in  1  arbiter has selected this slot; the incoming din belongs to it.
- req  out  1  request to arbiter; combinational.
- data_ok  out  1  dout valid for the current addr; combinational.
- dout  out  DW  read data; combinational.

Behaviour:
- Line index:
  - DW=8: line = addr[AW-1:2].
  - DW=16: line = addr[AW-1:1].
  - DW=32: line = addr.
  - Zero-extend line to SDRAMW bits.
- sdram_addr = offset + (line << 1), truncated to SDRAMW. Each line is two SDRAM words.
- Cache: entries E0 and E1. Each entry holds valid, tag (line) and data[31:0].
- hit = addr_ok AND, for E0 or E1, valid and tag == line.
- req = addr_ok AND NOT hit.
- data_ok = hit.
- dout source is the data of the hitting entry; E0 has priority when both hit. With no hit, dout uses E0 data and its value is undefined for the client.
- Byte/word select:
  - DW=8: addr[1:0] = 0,1,2,3 selects data[7:0], [15:8], [23:16], [31:24].
  - DW=16: addr[0] = 0,1 selects data[15:0], [31:16].
  - DW=32: full data.
- Pending tag register pend:
  - Every clock with we=0, pend <= line.
  - While we=1, pend holds. It therefore equals the line the arbiter latched when it selected this slot.
- Fill: on a clock with we=1 and din_ok=1:
  - E1 <= E0.
  - E0 <= {valid=1, tag=pend, data=din}.
  - This is shift replacement; the oldest entry is dropped.
- din_ok with we=0 is ignored; data belongs to another slot.
- clr=1 clears both valid bits next clock. clr has priority over a simultaneous fill, which is discarded.
- Reset:
  - Both entries invalid, tags 0, data 0, pend 0.
  - Outputs therefore: req=addr_ok, data_ok=0.
- Timing: a hit gives data_ok in the same cycle addr/addr_ok are presented.
- Miss latency: req is asserted immediately. The cycle after the we&din_ok fill edge, data_ok=1 and req=0 (if addr is unchanged).
- Address change mid-request: req and sdram_addr follow addr combinationally. The filled line is still tagged with pend, so stale data is never returned for a new address.
- No internal state machine beyond cache/pend registers. The arbiter owns sequencing.
- addr_ok=0: req=0 and data_ok=0; the cache is retained.

Test Plan:
- Reset then addr_ok=1, addr=0x05, DW=8, offset=0x100 -> req=1, data_ok=0, sdram_addr=0x102.
- Same cycle we=1; next cycle din_ok=1, din=0xDDCCBBAA -> next cycle req=0, data_ok=1, dout=0xBB. Then addr=0x07 -> dout=0xDD with no new req.
- Fill line 1, then line 2, then return to line 1 -> hit, no req. Fill line 3, then read line 1 -> miss, since E1 was evicted.
- DW=16, addr=0x03, din=0x5678_1234 after fill -> dout=0x5678. DW=32, addr=0x04, offset=0 -> sdram_addr=0x008.
- During we=1 wait, change addr to another line, then deliver din -> data_ok=0 and req=1 for the new line. Returning to the original addr hits with the original data.
- After fills, pulse clr=1 -> next cycle data_ok=0 and req=1. clr coincident with we&din_ok -> no entry valid afterward. din_ok with we=0 -> no state change.
